// File: rtl/mmio_ahblite_bridge.sv
`default_nettype none
// =============================================================================
// mmio_ahblite_bridge : single MMIO read/write requests -> AHB-Lite SINGLE xfers
// Rev 1.0
// =============================================================================
module mmio_ahblite_bridge #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wr_en,
   input  logic [ADDR_WIDTH-1:0]     wr_addr,
   input  logic [DATA_WIDTH-1:0]     wr_data,
   input  logic [DATA_WIDTH/8-1:0]   wr_byteen,
   input  logic                      rd_en,
   input  logic [ADDR_WIDTH-1:0]     rd_addr,
   output logic                      req_ready,
   output logic                      wr_done,
   output logic                      rd_done,
   output logic [DATA_WIDTH-1:0]     rd_data,
   output logic                      err,
   output logic [ADDR_WIDTH-1:0]     haddr,
   output logic [1:0]                htrans,
   output logic                      hwrite,
   output logic [2:0]                hsize,
   output logic [2:0]                hburst,
   output logic [3:0]                hprot,
   output logic                      hmastlock,
   output logic [DATA_WIDTH-1:0]     hwdata,
   input  logic [DATA_WIDTH-1:0]     hrdata,
   input  logic                      hready,
   input  logic                      hresp
);

   localparam int BW = DATA_WIDTH / 8;
   localparam int LB = $clog2(BW);

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_DATA = 2'd2,
      S_RESP = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [ADDR_WIDTH-1:0]  haddr_q, haddr_d;
   logic [1:0]             htrans_q, htrans_d;
   logic                   hwrite_q, hwrite_d;
   logic [2:0]             hsize_q, hsize_d;
   logic [DATA_WIDTH-1:0]  hwdata_q, hwdata_d;
   logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0]  rd_data_q, rd_data_d;
   logic                   dir_wr_q, dir_wr_d;
   logic                   err_rec_q, err_rec_d;
   logic                   req_ready_q, req_ready_d;
   logic                   wr_done_q, wr_done_d;
   logic                   rd_done_q, rd_done_d;
   logic                   err_q, err_d;

   // Byte lanes below the bus width are implied by byteen/size, never used directly.
   logic unused_addr_lsbs;
   assign unused_addr_lsbs = ^{wr_addr[LB-1:0], rd_addr[LB-1:0]};

   // Legal byteen: a run of 2**s ones starting at a multiple of 2**s.
   logic          be_legal;
   logic [2:0]    be_size;
   logic [LB-1:0] be_low;

   always_comb begin
      be_legal = 1'b0;
      be_size  = '0;
      be_low   = '0;
      for (int s = 0; s <= LB; s++) begin
         for (int k = 0; k < BW; k++) begin
            if (((k % (1 << s)) == 0) &&
                (wr_byteen == (BW'((1 << (1 << s)) - 1) << k))) begin
               be_legal = 1'b1;
               be_size  = 3'(s);
               be_low   = LB'(k);
            end
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      haddr_d   = haddr_q;
      htrans_d  = htrans_q;
      hwrite_d  = hwrite_q;
      hsize_d   = hsize_q;
      hwdata_d  = hwdata_q;
      wdata_d   = wdata_q;
      rd_data_d = rd_data_q;
      dir_wr_d  = dir_wr_q;
      err_rec_d = err_rec_q;

      case (state_q)
         S_IDLE: begin
            if (wr_en) begin
               dir_wr_d = 1'b1;
               wdata_d  = wr_data;
               if (be_legal) begin
                  haddr_d   = {wr_addr[ADDR_WIDTH-1:LB], be_low};
                  hsize_d   = be_size;
                  hwrite_d  = 1'b1;
                  htrans_d  = HTRANS_NONSEQ;
                  err_rec_d = 1'b0;
                  state_d   = S_ADDR;
               end else begin
                  err_rec_d = 1'b1;
                  state_d   = S_RESP;
               end
            end else if (rd_en) begin
               dir_wr_d  = 1'b0;
               haddr_d   = {rd_addr[ADDR_WIDTH-1:LB], {LB{1'b0}}};
               hsize_d   = 3'(LB);
               hwrite_d  = 1'b0;
               htrans_d  = HTRANS_NONSEQ;
               err_rec_d = 1'b0;
               state_d   = S_ADDR;
            end
         end
         S_ADDR: begin
            if (hready) begin
               htrans_d = HTRANS_IDLE;
               if (dir_wr_q) begin
                  hwdata_d = wdata_q;
               end
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (hready) begin
               err_rec_d = hresp;
               if (!dir_wr_q && !hresp) begin
                  rd_data_d = hrdata;
               end
               state_d = S_RESP;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Status outputs are registered so they line up with the RESP state.
      req_ready_d = (state_d == S_IDLE);
      wr_done_d   = (state_d == S_RESP) &&  dir_wr_d;
      rd_done_d   = (state_d == S_RESP) && !dir_wr_d;
      err_d       = (state_d == S_RESP) &&  err_rec_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         haddr_q     <= '0;
         htrans_q    <= HTRANS_IDLE;
         hwrite_q    <= 1'b0;
         hsize_q     <= '0;
         hwdata_q    <= '0;
         wdata_q     <= '0;
         rd_data_q   <= '0;
         dir_wr_q    <= 1'b0;
         err_rec_q   <= 1'b0;
         req_ready_q <= 1'b1;
         wr_done_q   <= 1'b0;
         rd_done_q   <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         haddr_q     <= haddr_d;
         htrans_q    <= htrans_d;
         hwrite_q    <= hwrite_d;
         hsize_q     <= hsize_d;
         hwdata_q    <= hwdata_d;
         wdata_q     <= wdata_d;
         rd_data_q   <= rd_data_d;
         dir_wr_q    <= dir_wr_d;
         err_rec_q   <= err_rec_d;
         req_ready_q <= req_ready_d;
         wr_done_q   <= wr_done_d;
         rd_done_q   <= rd_done_d;
         err_q       <= err_d;
      end
   end

   assign req_ready = req_ready_q;
   assign wr_done   = wr_done_q;
   assign rd_done   = rd_done_q;
   assign rd_data   = rd_data_q;
   assign err       = err_q;
   assign haddr     = haddr_q;
   assign htrans    = htrans_q;
   assign hwrite    = hwrite_q;
   assign hsize     = hsize_q;
   assign hwdata    = hwdata_q;
   assign hburst    = 3'b000;
   assign hprot     = 4'b0011;
   assign hmastlock = 1'b0;

endmodule
`default_nettype wire
